// File: rtl/stack_pkg.sv
// Shared types and sizes for the LIFO stack tile and its host-side master.
package stack_pkg;

  localparam int STACK_DEPTH = 256;
  localparam int STACK_DW    = 8;

  typedef enum logic {
    OP_PUSH = 1'b0,
    OP_POP  = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRIVE   = 2'd1,
    CAPTURE = 2'd2
  } master_state_e;

endpackage

// File: rtl/stack_phase_tracker.sv
// Follows the stack tile's free-running two-step phase. The first edge after
// reset release is the tile's step-0 (even) edge; ph=1 means the next edge is
// the step-1 (odd) edge.
module stack_phase_tracker (
  input  logic clk,
  input  logic rst_n,
  output logic odd_next,
  output logic even_next
);

  logic ph_q, ph_d;

  // ph flips on every edge
  always_comb ph_d = ~ph_q;

  // phase register, cleared with the tile so both agree on edge parity
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ph_q <= 1'b0;
    else        ph_q <= ph_d;
  end

  assign odd_next  = ph_q;
  assign even_next = ~ph_q;

endmodule

// File: rtl/stack_port_master.sv
// Host-side initiator for the LIFO stack tile: turns a valid/ready push/pop
// request stream into the tile's two-phase push/pop pins and returns popped
// bytes on a one-cycle strobe.
// Build option STACK_MASTER_GUARD_EN: when defined, a depth counter rejects
// overflow/underflow requests with err; otherwise every request reaches the
// tile and depth/err read 0.
module stack_port_master
  import stack_pkg::*;
#(
  parameter  int DEPTH = STACK_DEPTH,
  parameter  int DW    = STACK_DW,
  localparam int DCW   = $clog2(DEPTH) + 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic           req_op,
  input  logic [DW-1:0]  req_data,
  output logic           rsp_valid,
  output logic [DW-1:0]  rsp_data,
  output logic           err,
  output logic [DCW-1:0] depth,
  output logic           stk_push,
  output logic           stk_pop,
  output logic [DW-1:0]  stk_wdata,
  input  logic [DW-1:0]  stk_rdata
);

  localparam logic [1:0] ST_IDLE    = IDLE;
  localparam logic [1:0] ST_DRIVE   = DRIVE;
  localparam logic [1:0] ST_CAPTURE = CAPTURE;

  logic          odd_next, even_next;
  logic [1:0]    state_q, state_d;
  op_e           op_q, op_d;
  logic          push_q, push_d, pop_q, pop_d;
  logic [DW-1:0] wdata_q, wdata_d, rsp_data_q, rsp_data_d;
  logic          rsp_valid_q, rsp_valid_d, err_q, err_d;
  logic          accept, legal, req_is_pop;

  stack_phase_tracker u_phase (
    .clk       (clk),
    .rst_n     (rst_n),
    .odd_next  (odd_next),
    .even_next (even_next)
  );

  assign req_is_pop = (req_op == OP_POP);

  // Acceptance only on odd edges. The last DRIVE cycle of a push also accepts,
  // so pushes stream at one per two cycles with stk_push held high.
  assign req_ready = odd_next &
                     ((state_q == ST_IDLE) | ((state_q == ST_DRIVE) & (op_q == OP_PUSH)));
  assign accept    = req_valid & req_ready;

`ifdef STACK_MASTER_GUARD_EN
  localparam logic [DCW-1:0] DEPTH_FULL = DCW'(DEPTH);
  localparam logic [DCW-1:0] DEPTH_ONE  = DCW'(1);

  logic [DCW-1:0] depth_q, depth_d;

  assign legal = req_is_pop ? (depth_q != '0) : (depth_q < DEPTH_FULL);

  // depth moves at the acceptance edge of a legal request
  always_comb begin
    depth_d = depth_q;
    if (accept && legal) depth_d = req_is_pop ? (depth_q - DEPTH_ONE) : (depth_q + DEPTH_ONE);
  end

  // depth register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) depth_q <= '0;
    else        depth_q <= depth_d;
  end

  assign depth = depth_q;
`else
  assign legal = 1'b1;
  assign depth = '0;
`endif

  // sequencing: DRIVE spans one even and one odd edge, CAPTURE one even edge
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    push_d      = push_q;
    pop_d       = pop_q;
    wdata_d     = wdata_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      ST_DRIVE: begin
        if (odd_next) begin
          push_d  = 1'b0;
          pop_d   = 1'b0;
          wdata_d = '0;
          state_d = (op_q == OP_POP) ? ST_CAPTURE : ST_IDLE;
        end
      end
      ST_CAPTURE: begin
        // tile registered the byte on the preceding odd edge
        if (even_next) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = stk_rdata;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (accept) begin
      if (legal) begin
        state_d = ST_DRIVE;
        op_d    = req_is_pop ? OP_POP : OP_PUSH;
        push_d  = ~req_is_pop;
        pop_d   = req_is_pop;
        wdata_d = req_is_pop ? '0 : req_data;
      end else begin
        // consumed without tile traffic
        err_d   = 1'b1;
        state_d = ST_IDLE;
      end
    end
  end

  // control and datapath registers; all outputs clear asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_PUSH;
      push_q      <= 1'b0;
      pop_q       <= 1'b0;
      wdata_q     <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      push_q      <= push_d;
      pop_q       <= pop_d;
      wdata_q     <= wdata_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      err_q       <= err_d;
    end
  end

  assign stk_push  = push_q;
  assign stk_pop   = pop_q;
  assign stk_wdata = wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign err       = err_q;

endmodule

// File: tb/tb_stack_port_master.sv
// Directed bench for stack_port_master with a behavioural stack tile and a
// scoreboard of expected pop results.
module tb_stack_port_master;

`ifdef STACK_MASTER_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_op = 1'b0;
  logic [7:0] req_data = 8'h00;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       err;
  logic [8:0] depth;
  logic       stk_push, stk_pop;
  logic [7:0] stk_wdata, stk_rdata;

  always #5 clk = ~clk;

  stack_port_master dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .err(err), .depth(depth),
    .stk_push(stk_push), .stk_pop(stk_pop), .stk_wdata(stk_wdata), .stk_rdata(stk_rdata)
  );

  // behavioural tile: even edge write/decrement, odd edge increment/read
  logic [7:0] tmem [256];
  logic [7:0] tptr, tout;
  logic       tph;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tptr <= 8'd0; tph <= 1'b0; tout <= 8'd0;
    end else begin
      tph <= ~tph;
      if (!tph) begin
        if (stk_push)     tmem[tptr] <= stk_wdata;
        else if (stk_pop) tptr <= tptr - 8'd1;
      end else begin
        if (stk_push)     tptr <= tptr + 8'd1;
        else if (stk_pop) tout <= tmem[tptr];
      end
    end
  end
  assign stk_rdata = tout;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int rsp_cnt = 0, err_cnt = 0, push_cyc = 0, pop_cyc = 0, both_cnt = 0;
  always @(negedge clk) begin
    if (rsp_valid) rsp_cnt++;
    if (err) err_cnt++;
    if (stk_push) push_cyc++;
    if (stk_pop) pop_cyc++;
    if (stk_push && stk_pop) both_cnt++;
  end

  int checks = 0, failures = 0;
  int last_wait;
  logic [7:0] mstack [$];
  logic [7:0] exp_q [$];
  int         acc_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // issue one request; called just after a negedge, returns just after a negedge
  task automatic send(input bit op, input logic [7:0] d, output int acc);
    int n;
    bit legal;
    n = 0;
    acc = -1;
    req_valid = 1'b1; req_op = op; req_data = d;
    #1;
    while (!req_ready && n < 16) begin
      @(negedge clk); #1; n++;
    end
    if (!req_ready) begin
      chk("ready_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    last_wait = n;
    legal = !GUARD || (op ? (mstack.size() > 0) : (mstack.size() < 256));
    if (legal) begin
      if (op) exp_q.push_back(mstack.pop_back());
      else    mstack.push_back(d);
    end
    @(posedge clk); #1;
    acc = edge_cnt;
    if (op && legal) acc_q.push_back(acc);
    @(negedge clk);
    req_valid = 1'b0; req_op = 1'b0; req_data = ~d;
    #1;
    chk("err", 32'(err), 32'(!legal));
    chk("stk_push", 32'(stk_push), 32'(legal && !op));
    chk("stk_pop", 32'(stk_pop), 32'(legal && op));
    if (legal && !op) chk("stk_wdata", 32'(stk_wdata), 32'(d));
    chk("depth", 32'(depth), GUARD ? 32'(mstack.size()) : 32'd0);
  endtask

  task automatic wait_rsp();
    int n;
    logic [7:0] e;
    int a;
    n = 0;
    while (!rsp_valid && n < 12) begin
      @(negedge clk); #1; n++;
    end
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    if (exp_q.size() == 0 || acc_q.size() == 0) begin
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd1);
      return;
    end
    e = exp_q.pop_front();
    a = acc_q.pop_front();
    chk("rsp_data", 32'(rsp_data), 32'(e));
    chk("rsp_latency", 32'(edge_cnt - a), 32'd3);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    int a1, a2, a3, p1, p2, p3, e0, s0, s1;

    // reset state
    idle(3);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_depth", 32'(depth), 32'd0);
    chk("rst_stk", {29'd0, stk_push, stk_pop, |stk_wdata}, 32'd0);

    // release and push 0xA5 immediately: request raised while ph=0
    @(negedge clk);
    rst_n = 1'b1;
    e0 = edge_cnt + 1;
    s0 = push_cyc;
    send(1'b0, 8'hA5, a1);
    chk("ph0_wait", 32'(last_wait), 32'd1);
    chk("accept_odd", 32'((a1 - e0) % 2), 32'd1);
    idle(4);
    chk("push_width", 32'(push_cyc - s0), 32'd2);

    // back-to-back pushes then three pops
    s0 = rsp_cnt;
    send(1'b0, 8'h11, a1);
    send(1'b0, 8'h22, a2);
    send(1'b0, 8'h33, a3);
    chk("push_gap1", 32'(a2 - a1), 32'd2);
    chk("push_gap2", 32'(a3 - a2), 32'd2);
    send(1'b1, 8'h00, p1); wait_rsp();
    send(1'b1, 8'h00, p2); wait_rsp();
    send(1'b1, 8'h00, p3); wait_rsp();
    chk("pop_gap1", 32'(p2 - p1), 32'd4);
    chk("pop_gap2", 32'(p3 - p2), 32'd4);
    send(1'b1, 8'h00, p1); wait_rsp();
    idle(2);
    chk("rsp_count", 32'(rsp_cnt - s0), 32'd4);

`ifdef STACK_MASTER_GUARD_EN
    // underflow
    s0 = pop_cyc; s1 = err_cnt;
    send(1'b1, 8'h00, p1);
    idle(4);
    chk("uflow_no_pop", 32'(pop_cyc - s0), 32'd0);
    chk("uflow_err_once", 32'(err_cnt - s1), 32'd1);
    chk("uflow_depth", 32'(depth), 32'd0);
`endif

    // fill to capacity, then one more push
    for (int i = 0; i < 256; i++) send(1'b0, 8'(i) ^ 8'h3C, a1);
    idle(4);
    chk("full_depth", 32'(depth), GUARD ? 32'd256 : 32'd0);
    s0 = push_cyc; s1 = err_cnt;
    send(1'b0, 8'hFF, a1);
    idle(4);
    chk("oflow_push_cyc", 32'(push_cyc - s0), GUARD ? 32'd0 : 32'd2);
    chk("oflow_err", 32'(err_cnt - s1), GUARD ? 32'd1 : 32'd0);
    send(1'b1, 8'h00, p1); wait_rsp();

    // reset during a pop DRIVE
    send(1'b1, 8'h00, p1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_stk_pop", 32'(stk_pop), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    chk("mid_rst_depth", 32'(depth), 32'd0);
    chk("mid_rst_rsp", 32'(rsp_valid), 32'd0);
    mstack.delete(); exp_q.delete(); acc_q.delete();
    s0 = rsp_cnt;
    idle(2);
    @(negedge clk);
    rst_n = 1'b1;
    idle(8);
    chk("post_rst_no_rsp", 32'(rsp_cnt - s0), 32'd0);
    chk("post_rst_depth", 32'(depth), 32'd0);

    // recovery
    send(1'b0, 8'h5C, a1);
    send(1'b1, 8'h00, p1); wait_rsp();
    chk("onehot_push_pop", 32'(both_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL global_timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/stack_port_master.md
# stack_port_master

Host-side initiator for the 8-bit, 256-entry LIFO stack tile. Converts a valid/ready request stream (push byte / pop) into the tile's two-phase push/pop pin protocol, tracks the tile's free-running step phase and current depth, and returns popped bytes on a one-cycle response strobe. It sits between on-chip request logic and the stack tile's `ui_in[1:0]`, `uio_in` and `uo_out` pins, sharing their clock and reset.

## Interface
- `DEPTH`, 256: stack entries in the tile; the depth counter is `$clog2(DEPTH)+1` bits wide.
- `DW`, 8: data width.

- `clk`  in  1  clock, shared with the stack tile
- `rst_n`  in  1  asynchronous active-low reset, shared with the stack tile
- `req_valid`  in  1  request present
- `req_ready`  out  1  request accepted on the edge where valid&ready
- `req_op`  in  1  0 = push, 1 = pop
- `req_data`  in  DW  push byte
- `rsp_valid`  out  1  one-cycle strobe: `rsp_data` holds a popped byte
- `rsp_data`  out  DW  popped byte, held until the next response
- `err`  out  1  one-cycle strobe: request rejected (overflow or underflow)
- `depth`  out  9  entries currently on the stack
- `stk_push`  out  1  to tile `ui_in[0]`
- `stk_pop`  out  1  to tile `ui_in[1]`
- `stk_wdata`  out  DW  to tile `uio_in`
- `stk_rdata`  in  DW  from tile `uo_out`

## Operation
- Reset values: all outputs 0; `ph`=0; state IDLE. Outputs return to 0 asynchronously when `rst_n` falls, including mid-operation.
- Phase: the edge after reset release is E0, the tile's step-0 edge. Internal `ph` toggles on every edge. `ph`=1 means the next edge is odd, which is the tile's step-1 edge.
- The tile samples on every edge:
  - even edge: push writes the byte, or pop decrements the pointer;
  - odd edge: push increments the pointer, or pop registers the output byte.
  - `stk_push`/`stk_pop` must therefore be stable across one even edge and the following odd edge.
- States: IDLE, DRIVE, CAPTURE.
  - IDLE: `req_ready` = IDLE & `ph`=1. On acceptance of a legal request at odd edge A, go to DRIVE. `stk_push`/`stk_pop` and `stk_wdata` are registered high/valid at A.
  - DRIVE: lasts edges A+1 (even) and A+2 (odd). At A+2, outputs drop. A push returns to IDLE, with `req_ready` high in the same cycle, which gives back-to-back operation. A pop goes to CAPTURE.
  - CAPTURE: at A+3 (even), register `stk_rdata` into `rsp_data`, pulse `rsp_valid`, and return to IDLE. The next acceptance is possible at A+4.
- Only one of `stk_push`/`stk_pop` is ever high. The encoding is `req_op`, so simultaneous push and pop cannot be requested.
- Depth (guard enabled):
  - push is legal when depth < DEPTH; pop is legal when depth > 0;
  - depth updates at the acceptance edge: +1 for push, −1 for pop.
- Illegal request: still handshaken (consumed). No tile traffic. `err` pulses in the cycle after acceptance. depth is unchanged. State stays IDLE, so the next acceptance is possible 2 cycles later.
- `req_data` is captured at acceptance. It is not required to be stable afterwards.

## Timing
- Push: accept edge A, tile holds the byte after A+1, pointer advances at A+2.
- Pop: `rsp_valid` is high in cycle [A+3, A+4). Latency from acceptance is 3 edges.
- Throughput: 1 push per 2 cycles, 1 pop per 4 cycles.
- `req_ready` is never high while `ph`=0. A request raised at `ph`=0 waits 1 cycle.
- If reset is asserted mid-DRIVE, the tile and the master both reset; depth returns to 0 and no response is produced.

## Configuration
- `STACK_MASTER_GUARD_EN`:
  - defined: depth counter active, overflow/underflow requests rejected with `err`;
  - undefined: every request is forwarded to the tile, `err` is tied 0, `depth` is tied 0, and a pop on an empty stack returns whatever byte the tile registers (pointer wraps 0→255).

## Structure
- Package `stack_pkg`: `STACK_DEPTH`=256, `STACK_DW`=8, `op_e` {OP_PUSH=0, OP_POP=1}, `master_state_e` {IDLE, DRIVE, CAPTURE}.
- Sub-module `stack_phase_tracker`: resettable `ph` toggle plus the odd-edge qualifier. The stack tile's own tests reuse it as a model.

## Test plan
- Reset, then push 0xA5 at the first ready: `stk_push` is high for exactly 2 cycles starting at an odd edge, `stk_wdata`=0xA5, depth becomes 1.
- Push 0x11, 0x22, 0x33 back-to-back, then 3 pops: `rsp_data` is 0x33, 0x22, 0x11, each 3 edges after its acceptance.
- Pop at depth 0 (guard on): `err` pulses once, `stk_pop` never rises, depth stays 0.
- 256 pushes, then push 0xFF: `err` pulses, depth=256, no `stk_push`. Then a pop returns the 256th byte.
- `req_valid` raised when `ph`=0: `req_ready` stays low for 1 cycle, and acceptance happens at the following odd edge.
- `rst_n` asserted during a pop DRIVE: outputs are 0 immediately, no `rsp_valid`, depth is 0 after release.
